spi_reg_slave: RTL and testbench

//  SPI slave (mode 0, MSB first) exposing a byte-wide register bank to an external SPI master.

---
 rtl/spi_reg_slave_pkg.sv | 20 ++
 rtl/spi_reg_slave_sync_edge.sv | 34 +++
 rtl/spi_reg_slave.sv | 166 ++++++++++++++++
 tb/tb_spi_reg_slave.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_slave_pkg.sv
// rtl/spi_reg_slave_pkg.sv - shared constants, state type and address helper for the SPI register slave
package spi_reg_slave_pkg;

  localparam int SPI_RW_BIT = 7;
  localparam int SPI_ADDR_W = 7;
  localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA
  } state_t;

  // Burst increment: wraps at the last implemented register, otherwise plain 7-bit increment.
  function automatic logic [SPI_ADDR_W-1:0] addr_next(input logic [SPI_ADDR_W-1:0] a,
                                                      input logic [SPI_ADDR_W-1:0] last);
    return (a == last) ? '0 : a + 1'b1;
  endfunction

endpackage

// File: rtl/spi_reg_slave_sync_edge.sv
// rtl/spi_reg_slave_sync_edge.sv - multi-flop synchronizer with rise/fall detection on the synchronized level
module spi_reg_slave_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    hist_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign rise = sync_q[STAGES-1] & ~hist_q;
  assign fall = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_reg_slave.sv
// rtl/spi_reg_slave.sv - mode-0 SPI slave giving an external master burst access to a byte register bank
module spi_reg_slave
  import spi_reg_slave_pkg::*;
#(
  parameter int REG_COUNT   = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_ss,
  input  logic                  spi_sck,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  input  logic                  load_en,
  input  logic [SPI_ADDR_W-1:0] load_addr,
  input  logic [7:0]            load_data,
  output logic                  wr_valid,
  output logic [SPI_ADDR_W-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [7:0] REG_LIMIT = 8'(REG_COUNT);
  localparam logic [SPI_ADDR_W-1:0] ADDR_LAST = SPI_ADDR_W'(REG_COUNT - 1);

  logic ss_rise, ss_fall, sck_rise, sck_fall, mosi_s;
  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;

  // ss chain resets low: only a genuine high-then-low seen after reset can start a transfer.
  spi_reg_slave_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ss_sync (
    .clk(clk), .rst(rst), .d(spi_ss), .rise(ss_rise), .fall(ss_fall)
  );
  spi_reg_slave_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .d(spi_sck), .rise(sck_rise), .fall(sck_fall)
  );

  assign mosi_d = {mosi_q[SYNC_STAGES-2:0], spi_mosi};
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  state_t                state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [6:0]            rx_sr_q, rx_sr_d;
  logic [7:0]            tx_sr_q, tx_sr_d;
  logic [SPI_ADDR_W-1:0] addr_q, addr_d, addr_inc, rd_addr;
  logic                  rw_q, rw_d, miso_q, miso_d;
  logic                  wr_valid_q, wr_valid_d, done_q, done_d;
  logic [SPI_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]            wr_data_q, wr_data_d, rx_next, rd_data;
  logic                  spi_we, load_ok, mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [7:0]            mem_wdata;
  logic [7:0]            regs_q [REG_COUNT];

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sr_d    = rx_sr_q;
    tx_sr_d    = tx_sr_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    miso_d     = miso_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    spi_we     = 1'b0;
    rx_next    = {rx_sr_q, mosi_s};
    addr_inc   = addr_next(addr_q, ADDR_LAST);
    rd_addr    = (state_q == ST_CMD) ? rx_next[SPI_ADDR_W-1:0] : addr_inc;
    rd_data    = ({1'b0, rd_addr} < REG_LIMIT) ? regs_q[rd_addr[AW-1:0]] : 8'h00;

    if (ss_rise) begin
      done_d  = (state_q != ST_IDLE);
      state_d = ST_IDLE;
      miso_d  = 1'b1;
    end else if (ss_fall) begin
      state_d   = ST_CMD;
      bit_cnt_d = 3'd0;
      rx_sr_d   = 7'd0;
      tx_sr_d   = SPI_IDLE_BYTE;
    end else if (state_q != ST_IDLE) begin
      if (sck_rise) begin
        rx_sr_d   = rx_next[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (state_q == ST_CMD) begin
            rw_d    = rx_next[SPI_RW_BIT];
            addr_d  = rx_next[SPI_ADDR_W-1:0];
            tx_sr_d = rx_next[SPI_RW_BIT] ? rd_data : SPI_IDLE_BYTE;
            state_d = ST_DATA;
          end else if (rw_q) begin
            addr_d  = addr_inc;
            tx_sr_d = rd_data;
          end else begin
            spi_we     = ({1'b0, addr_q} < REG_LIMIT);
            wr_valid_d = spi_we;
            if (spi_we) begin
              wr_addr_d = addr_q;
              wr_data_d = rx_next;
            end
            addr_d = addr_inc;
          end
        end
      end else if (sck_fall) begin
        miso_d  = tx_sr_q[7];
        tx_sr_d = {tx_sr_q[6:0], 1'b1};
      end
    end
  end

  // Single write port: the fabric load takes the port when it collides with an SPI commit.
  always_comb begin
    load_ok   = load_en & ({1'b0, load_addr} < REG_LIMIT);
    mem_we    = load_ok | spi_we;
    mem_waddr = load_ok ? load_addr[AW-1:0] : addr_q[AW-1:0];
    mem_wdata = load_ok ? load_data : rx_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      rx_sr_q    <= 7'd0;
      tx_sr_q    <= SPI_IDLE_BYTE;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      miso_q     <= 1'b1;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
      done_q     <= 1'b0;
      mosi_q     <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sr_q    <= rx_sr_d;
      tx_sr_q    <= tx_sr_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      miso_q     <= miso_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      mosi_q     <= mosi_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= 8'h00;
    end else if (mem_we) begin
      regs_q[mem_waddr] <= mem_wdata;
    end
  end

  assign spi_miso = miso_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb/tb_spi_reg_slave.sv - directed and randomized SPI transactions against a register-bank reference model
module tb_spi_reg_slave;

  localparam int RC   = 64;
  localparam int HALF = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_ss = 1'b1, spi_sck = 1'b0, spi_mosi = 1'b0;
  logic       spi_miso;
  logic       load_en = 1'b0;
  logic [6:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic       wr_valid, busy, done;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  spi_reg_slave #(.REG_COUNT(RC), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_ss(spi_ss), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [14:0] wr_log[$];
  logic [7:0]  mem_m [128];
  logic [7:0]  wq[$];

  always @(negedge clk) begin
    if (wr_valid === 1'b1) wr_log.push_back({wr_addr, wr_data});
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_reg(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    if (a < RC) mem_m[a] = d;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit collide,
                          output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = tx[i];
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b1;
      rx[i] = spi_miso;
      if (collide && i == 0) begin
        repeat (2) @(negedge clk);
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        repeat (HALF - 3) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      spi_sck = 1'b0;
    end
  endtask

  task automatic ss_lo();
    @(negedge clk);
    spi_ss = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic ss_hi();
    repeat (HALF) @(negedge clk);
    spi_ss = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // One full transaction; expectations come from the model array and burst rules.
  task automatic run_txn(input logic [7:0] cmd, input int n);
    logic [6:0]  a;
    logic [7:0]  rx, d, exp_b;
    logic [14:0] exp_w[$];
    int          base;
    a    = cmd[6:0];
    base = wr_log.size();
    ss_lo();
    spi_bits(cmd, 8, 1'b0, rx);
    check("cmd_miso", rx, 8'hFF);
    for (int k = 0; k < n; k++) begin
      d = cmd[7] ? 8'hFF : wq[k];
      spi_bits(d, 8, 1'b0, rx);
      if (cmd[7]) begin
        exp_b = (a < RC) ? mem_m[a] : 8'h00;
        check("rd_data", rx, exp_b);
      end else begin
        if (a < RC) begin
          mem_m[a] = d;
          exp_w.push_back({a, d});
        end
        check("wr_miso", rx, 8'hFF);
      end
      a = (a == 7'(RC - 1)) ? 7'd0 : a + 7'd1;
    end
    ss_hi();
    check("wr_count", wr_log.size() - base, exp_w.size());
    for (int k = 0; k < exp_w.size(); k++)
      if (base + k < wr_log.size()) check("wr_entry", wr_log[base + k], exp_w[k]);
    check("busy_after", busy, 1'b0);
  endtask

  initial begin
    logic [7:0] rx;
    int         dbase, wbase;
    for (int i = 0; i < 128; i++) mem_m[i] = 8'h00;

    repeat (5) @(negedge clk);
    check("rst_miso", spi_miso, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_wr_addr", wr_addr, 7'h00);
    check("rst_wr_data", wr_data, 8'h00);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    load_reg(7'h3C, 8'hA5);
    dbase = done_cnt;
    run_txn(8'hBC, 1);
    check("done_once", done_cnt - dbase, 1);

    wq = '{8'h5A, 8'hC3};
    run_txn(8'h12, 2);
    run_txn(8'h92, 2);

    load_reg(7'h3F, 8'h3F ^ 8'($urandom));
    load_reg(7'h00, 8'($urandom));
    load_reg(7'h01, 8'($urandom));
    run_txn(8'hBF, 3);

    load_reg(7'h05, 8'h77);
    wbase = wr_log.size();
    ss_lo();
    spi_bits(8'h05, 8, 1'b0, rx);
    spi_bits(8'hE1, 5, 1'b0, rx);
    ss_hi();
    check("partial_no_wr", wr_log.size() - wbase, 0);
    check("partial_busy", busy, 1'b0);
    run_txn(8'h85, 1);

    load_addr = 7'h20;
    load_data = 8'h11;
    wbase = wr_log.size();
    ss_lo();
    spi_bits(8'h20, 8, 1'b0, rx);
    spi_bits(8'h22, 8, 1'b1, rx);
    ss_hi();
    mem_m[7'h20] = 8'h11;
    check("coll_wr_count", wr_log.size() - wbase, 1);
    if (wr_log.size() > wbase) check("coll_wr_entry", wr_log[wbase], {7'h20, 8'h22});
    run_txn(8'hA0, 1);

    for (int t = 0; t < 10; t++) begin
      logic [6:0] ra;
      int         rn;
      if ($urandom_range(0, 1) == 1) load_reg(7'($urandom_range(0, RC - 1)), 8'($urandom));
      ra = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(RC - 6, RC - 1));
      rn = $urandom_range(1, 4);
      wq.delete();
      for (int k = 0; k < rn; k++) wq.push_back(8'($urandom));
      run_txn({1'($urandom_range(0, 1)), ra}, rn);
    end

    for (int i = 0; i < 4; i++) load_reg(7'(i), 8'(i + 8'h40));
    ss_lo();
    spi_bits(8'h80, 8, 1'b0, rx);
    spi_bits(8'hFF, 3, 1'b0, rx);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_miso", spi_miso, 1'b1);
    check("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 128; i++) mem_m[i] = 8'h00;
    spi_bits(8'h80, 8, 1'b0, rx);
    check("lowss_busy", busy, 1'b0);
    check("lowss_miso", rx, 8'hFF);
    ss_hi();
    run_txn(8'h80, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
